// File: rtl/mux2_arb_pkg.sv
// Shared encodings for the two-requester round-robin arbiter.
// No logic here; state and side constants only.
// Imported by the arbiter and its bench.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/mux2to1_w.sv
// Width-parameterised 2:1 data multiplexer, s=0 selects a, s=1 selects b.
// Purely combinational, zero latency.
// No flow control; the arbiter owns the select and the handshake.
module mux2to1_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] f
);

    assign f = s ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B; MUX2_ARB_STATS_EN adds per-side beat counters.
// Latency: grant one cycle after req in IDLE; handover between sides is direct with no idle bubble.
// Backpressure: out_ready low holds state, select and beat count; ready_a/ready_b only pulse on accepted beats.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b,
    output logic             ready_a,
    output logic             ready_b,
    output logic [WIDTH-1:0] f,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MUX2_ARB_STATS_EN
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b,
`endif
    output logic             s
);

    localparam int            CW        = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_HOLD - 1);

    state_t        state, state_nxt;
    logic          s_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] beat_cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            s        <= SIDE_A;
            last     <= SIDE_B;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            s        <= s_nxt;
            last     <= last_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        last_nxt  = last;
        cnt_nxt   = beat_cnt;
        out_valid = 1'b0;
        ready_a   = 1'b0;
        ready_b   = 1'b0;
        case (state)
            ST_IDLE: begin
                // On a tie the side that did not hold the last grant wins.
                if (req_a && (!req_b || last == SIDE_B)) begin
                    state_nxt = ST_GNT_A;
                    s_nxt     = SIDE_A;
                    last_nxt  = SIDE_A;
                    cnt_nxt   = '0;
                end else if (req_b) begin
                    state_nxt = ST_GNT_B;
                    s_nxt     = SIDE_B;
                    last_nxt  = SIDE_B;
                    cnt_nxt   = '0;
                end
            end
            ST_GNT_A: begin
                out_valid = req_a;
                ready_a   = req_a & out_ready;
                if (!req_a || (out_ready && beat_cnt == LAST_BEAT && req_b)) begin
                    if (req_b) begin
                        state_nxt = ST_GNT_B;
                        s_nxt     = SIDE_B;
                        last_nxt  = SIDE_B;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (out_ready) begin
                    cnt_nxt = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
                end
            end
            ST_GNT_B: begin
                out_valid = req_b;
                ready_b   = req_b & out_ready;
                if (!req_b || (out_ready && beat_cnt == LAST_BEAT && req_a)) begin
                    if (req_a) begin
                        state_nxt = ST_GNT_A;
                        s_nxt     = SIDE_A;
                        last_nxt  = SIDE_A;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (out_ready) begin
                    cnt_nxt = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mux2to1_w #(.WIDTH(WIDTH)) u_mux (
        .a (a),
        .b (b),
        .s (s),
        .f (f)
    );

`ifdef MUX2_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (ready_a) cnt_a <= cnt_a + 16'd1;
            if (ready_b) cnt_b <= cnt_b + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter that shares one 2:1 multiplexer datapath between two requesters (A, B) and forwards the selected word to a single downstream consumer over a valid/ready handshake. The block owns the mux select line: it registers grants, bounds each grant to a maximum number of accepted beats, and hands over between requesters without an idle bubble. It sits between two producer blocks and one shared consumer port in the lab datapath.

## Interface
- WIDTH, 8: data word width in bits.
- MAX_HOLD, 4: maximum accepted beats per grant while the other side is requesting; legal range is MAX_HOLD ≥ 1.

Ports (reset is synchronous and active-high; one clock, `clk`, rising edge):
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- req_a  input  1  requester A has a word on a.
- a  input  WIDTH  requester A data.
- req_b  input  1  requester B has a word on b.
- b  input  WIDTH  requester B data.
- ready_a  output  1  A's word accepted this cycle.
- ready_b  output  1  B's word accepted this cycle.
- f  output  WIDTH  muxed data to the consumer.
- out_valid  output  1  f holds a valid word.
- out_ready  input  1  consumer accepts f this cycle.
- s  output  1  registered mux select; 0 selects a, 1 selects b.

## Operation
- States: IDLE, GNT_A, GNT_B. Registers: state, s, last (last granted side), beat_cnt.
- Combinational outputs:
  - f = s ? b : a.
  - out_valid = (GNT_A & req_a) | (GNT_B & req_b).
  - ready_a = GNT_A & req_a & out_ready.
  - ready_b = GNT_B & req_b & out_ready.
- A beat is a cycle with out_valid & out_ready.
- IDLE transitions:
  - Only req_a → GNT_A.
  - Only req_b → GNT_B.
  - Both → the side ≠ last.
  - Neither → stay in IDLE.
- GNT_A transitions (GNT_B is symmetric):
  - req_a low and req_b high → GNT_B.
  - req_a low and req_b low → IDLE.
  - Beat with beat_cnt == MAX_HOLD-1 and req_b high → GNT_B.
  - Beat with beat_cnt == MAX_HOLD-1 and req_b low → stay in GNT_A, beat_cnt ← 0.
  - Any other beat → beat_cnt ← beat_cnt + 1.
  - No beat (consumer stall) → hold state and beat_cnt.
- On entry to a GNT state: s set to that side, last ← that side, beat_cnt ← 0.
- Requesters hold data stable while req is high and ready is low. Dropping req before acceptance is legal; the arbiter moves on without a beat.
- beat_cnt width is $clog2(MAX_HOLD)+1; it never exceeds MAX_HOLD-1.

## Timing
- Reset values: state=IDLE, s=0, last=B (so A wins the first tie), beat_cnt=0, out_valid=0, ready_a=0, ready_b=0. f then equals a.
- Grant latency: req rising in IDLE → GNT state and out_valid on the next clock edge (one cycle).
- Handover A→B is direct: B is valid in the cycle after A's last beat, with no IDLE cycle.
- The consumer sees at most one word per cycle. Back-to-back beats run at one per cycle while out_ready stays high.
- s changes only on state entry, so it is stable throughout a grant.
- Reset mid-grant: the next edge forces all reset values. An in-flight word is dropped, and its requester re-requests.

## Configuration
- MUX2_ARB_STATS_EN defined:
  - Adds output ports cnt_a and cnt_b, each 16 bits, counting accepted beats per side.
  - Both counters reset to 0 and wrap modulo 2^16.
- Undefined: ports and counters are absent. Arbitration behaviour is identical.

## Structure
- Package mux2_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GNT_A=2'd1, ST_GNT_B=2'd2.
  - side constants SIDE_A=1'b0, SIDE_B=1'b1.
- Sub-module mux2to1_w: a WIDTH-parameterised 2:1 mux (ports a, b, s, f). The arbiter instantiates it for f; all control stays in the arbiter.

## Test plan
- Reset: rst=1 for 2 cycles with req_a=req_b=1 → out_valid=0, s=0, state IDLE. After release, GNT_A is entered in 1 cycle with f=a.
- Single requester: req_a=1, a=8'h3C, out_ready=1 for 10 cycles, req_b=0 → 10 consecutive beats on A. beat_cnt wraps every 4 beats, and s stays 0.
- Contention with MAX_HOLD=4: both req high, out_ready=1 → grant sequence is 4 beats of A, then 4 of B, then 4 of A. ready_a and ready_b are never high together, and there is no IDLE cycle between grants.
- Stall: in GNT_B after 2 beats, out_ready=0 for 5 cycles → state, s=1 and beat_cnt=2 are held. After release, 2 more B beats occur before handover.
- Early drop: in GNT_A, req_a falls after 1 beat while req_b=1 → GNT_B on the next edge and s=1. If req_b=0 instead → IDLE and out_valid=0.
- With MUX2_ARB_STATS_EN: run the contention case for 24 cycles → cnt_a=12 and cnt_b=12. A reset mid-run zeroes both counters.
